// File: rtl/rtc_disp_pkg.sv
// -----------------------------------------------------------------------------
// rtc_disp_pkg
// Shared definitions for the RTC display page selector:
//   - page_e   : display page encoding (TIME / DATE)
//   - DOT_*    : decimal-point masks per page (bit 5 = leftmost digit)
//   - *_MIN/MAX: BCD calendar field bounds used by the range checker
//   - bcd_in_range(): inclusive range test on a packed-BCD byte
// -----------------------------------------------------------------------------
package rtc_disp_pkg;

  typedef enum logic {
    PAGE_TIME = 1'b0,
    PAGE_DATE = 1'b1
  } page_e;

  // Both pages light the dots after digits 2 and 4 (HH.MM.SS / YY.MO.DD).
  localparam logic [5:0] DOT_TIME = 6'b010100;
  localparam logic [5:0] DOT_DATE = 6'b010100;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] DAY_MIN  = 8'h01;
  localparam logic [7:0] DAY_MAX  = 8'h31;
  localparam logic [7:0] MON_MIN  = 8'h01;
  localparam logic [7:0] MON_MAX  = 8'h12;

  // Binary compare is order-preserving for packed BCD once both nibbles
  // are known to be decimal, so a plain magnitude compare is sufficient.
  function automatic logic bcd_in_range(input logic [7:0] val,
                                        input logic [7:0] lo,
                                        input logic [7:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/rtc_bcd_check.sv
// -----------------------------------------------------------------------------
// rtc_bcd_check
// Combinational legality check of one displayed 6-digit page.
// Ports:
//   page_data_i [23:0] : three packed-BCD fields, [23:16] leftmost
//   page_date_i        : 0 = TIME page (HH MI SS), 1 = DATE page (YY MO DD)
//   legal_o            : 1 when every nibble is decimal and every field is
//                        inside its calendar range
// -----------------------------------------------------------------------------
module rtc_bcd_check
  import rtc_disp_pkg::*;
(
  input  logic [23:0] page_data_i,
  input  logic        page_date_i,
  output logic        legal_o
);

  logic [5:0] nib_ok;
  logic [7:0] fld_hi;
  logic [7:0] fld_mid;
  logic [7:0] fld_lo;
  logic       range_ok;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_nib
      assign nib_ok[gi] = (page_data_i[gi*4 +: 4] <= 4'd9);
    end
  endgenerate

  assign fld_hi  = page_data_i[23:16];
  assign fld_mid = page_data_i[15:8];
  assign fld_lo  = page_data_i[7:0];

  always_comb begin
    range_ok = 1'b0;
    if (page_date_i) begin
      // Year is unbounded beyond BCD legality; month and day exclude 00.
      range_ok = bcd_in_range(fld_mid, MON_MIN, MON_MAX) &&
                 bcd_in_range(fld_lo,  DAY_MIN, DAY_MAX);
    end else begin
      range_ok = (fld_hi  <= HOUR_MAX) &&
                 (fld_mid <= SEC_MAX)  &&
                 (fld_lo  <= SEC_MAX);
    end
  end

  assign legal_o = (&nib_ok) && range_ok;

endmodule

// File: rtl/rtc_disp_mux.sv
// -----------------------------------------------------------------------------
// rtc_disp_mux
// Display page selector between the PCF8563 controller and the seg driver.
// Captures the 48-bit BCD calendar word on each valid strobe and presents a
// 6-digit page (TIME = HH MI SS, DATE = YY MO DD). A key press toggles the
// page; the DATE page falls back to TIME after RETURN_TICKS half-second ticks.
//
// Optional feature macro: RTC_DISP_CHECK_EN
//   defined   : range-checks the displayed page, drives data_err and blinks
//               the whole display (blank_mask) while the page is illegal.
//   undefined : no checker; data_err and blank_mask are constant 0.
//
// Parameters:
//   HALF_SEC_MAX : terminal count of the half-second tick divider
//   RETURN_TICKS : ticks spent on DATE before auto-return to TIME
// Ports:
//   sys_clk, sys_rstn   : clock, asynchronous active-low reset
//   time_bcd [47:0]     : {YY,MO,DD,HH,MI,SS} packed BCD
//   time_vld            : one-cycle strobe qualifying time_bcd
//   key_flag            : one-cycle debounced key press
//   disp_data [23:0]    : digits to seg driver, [23:20] leftmost
//   dot_mask [5:0]      : decimal points, bit 5 leftmost, 1 = lit
//   blank_mask [5:0]    : 1 = digit dark
//   page                : 0 = TIME, 1 = DATE
//   data_err            : displayed page holds an illegal field
// All outputs are registered.
// -----------------------------------------------------------------------------
module rtc_disp_mux
  import rtc_disp_pkg::*;
#(
  parameter logic [24:0] HALF_SEC_MAX = 25'd24_999_999,
  parameter logic [4:0]  RETURN_TICKS = 5'd10
) (
  input  logic        sys_clk,
  input  logic        sys_rstn,
  input  logic [47:0] time_bcd,
  input  logic        time_vld,
  input  logic        key_flag,
  output logic [23:0] disp_data,
  output logic [5:0]  dot_mask,
  output logic [5:0]  blank_mask,
  output logic        page,
  output logic        data_err
);

  logic [47:0] shadow_q, shadow_d;
  logic [24:0] div_q, div_d;
  logic        tick;
  page_e       page_q, page_d;
  logic [4:0]  tmo_q, tmo_d;
  logic [23:0] disp_q, disp_d;
  logic [5:0]  dot_q, dot_d;
  logic [23:0] page_data;

  // ---------------------------------------------------------------------------
  // Shadow register and free-running half-second divider
  // ---------------------------------------------------------------------------
  assign shadow_d = time_vld ? time_bcd : shadow_q;
  assign tick     = (div_q == HALF_SEC_MAX);
  assign div_d    = tick ? '0 : div_q + 25'd1;

  // ---------------------------------------------------------------------------
  // Page FSM. A key press always wins over the timeout so a coincident key
  // and timeout produce exactly one DATE->TIME transition.
  // ---------------------------------------------------------------------------
  always_comb begin
    page_d = page_q;
    tmo_d  = tmo_q;
    case (page_q)
      PAGE_TIME: begin
        if (key_flag) begin
          page_d = PAGE_DATE;
          tmo_d  = '0;
        end
      end
      PAGE_DATE: begin
        if (key_flag) begin
          page_d = PAGE_TIME;
          tmo_d  = '0;
        end else if (tick) begin
          if (tmo_q + 5'd1 == RETURN_TICKS) begin
            page_d = PAGE_TIME;
            tmo_d  = '0;
          end else begin
            tmo_d = tmo_q + 5'd1;
          end
        end
      end
      default: begin
        page_d = PAGE_TIME;
        tmo_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output mux: selects from the registered page, so a key press reaches the
  // data outputs one cycle after it reaches the page output.
  // ---------------------------------------------------------------------------
  assign page_data = (page_q == PAGE_DATE) ? shadow_q[47:24] : shadow_q[23:0];
  assign disp_d    = page_data;
  assign dot_d     = (page_q == PAGE_DATE) ? DOT_DATE : DOT_TIME;

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      shadow_q <= '0;
      div_q    <= '0;
      page_q   <= PAGE_TIME;
      tmo_q    <= '0;
      disp_q   <= '0;
      dot_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      div_q    <= div_d;
      page_q   <= page_d;
      tmo_q    <= tmo_d;
      disp_q   <= disp_d;
      dot_q    <= dot_d;
    end
  end

  assign disp_data = disp_q;
  assign dot_mask  = dot_q;
  assign page      = page_q;

`ifdef RTC_DISP_CHECK_EN
  // ---------------------------------------------------------------------------
  // Range check and blink. The error flag is registered alongside disp_data
  // so it always describes the digits currently shown. blank is derived from
  // the next-state error and blink values so the registered blank_mask
  // agrees with the registered data_err and blink phase in the same cycle.
  // ---------------------------------------------------------------------------
  logic       page_legal;
  logic       err_q, err_d;
  logic       blink_q, blink_d;
  logic [5:0] blank_q, blank_d;

  rtc_bcd_check u_check (
    .page_data_i (page_data),
    .page_date_i (page_q == PAGE_DATE),
    .legal_o     (page_legal)
  );

  assign err_d   = ~page_legal;
  assign blink_d = tick ? ~blink_q : blink_q;
  assign blank_d = (err_d && blink_d) ? 6'h3F : 6'h00;

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      err_q   <= 1'b0;
      blink_q <= 1'b0;
      blank_q <= '0;
    end else begin
      err_q   <= err_d;
      blink_q <= blink_d;
      blank_q <= blank_d;
    end
  end

  assign data_err   = err_q;
  assign blank_mask = blank_q;
`else
  assign data_err   = 1'b0;
  assign blank_mask = 6'h00;
`endif

endmodule

// File: tb/tb_rtc_disp_mux.sv
// -----------------------------------------------------------------------------
// tb_rtc_disp_mux
// Directed bench for rtc_disp_mux with a fast divider (HALF_SEC_MAX = 9,
// RETURN_TICKS = 3). Expected outputs are queued with the clock-edge index at
// which they must appear (edges counted since reset release) and checked when
// that edge is reached. The tick falls on every PER-th edge after reset, so
// blink phase and auto-return edges are derived from the edge index.
// -----------------------------------------------------------------------------
module tb_rtc_disp_mux;

  localparam int HSM = 9;
  localparam int RT  = 3;
  localparam int PER = HSM + 1;

`ifdef RTC_DISP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [47:0] T1 = 48'h23_12_14_19_18_00;
  localparam logic [47:0] T2 = 48'h24_01_31_23_59_59;
  localparam logic [47:0] T3 = 48'h23_12_14_12_34_5A;
  localparam logic [47:0] T4 = 48'h99_13_00_24_00_00;

  logic        sys_clk  = 1'b0;
  logic        sys_rstn = 1'b0;
  logic [47:0] time_bcd = '0;
  logic        time_vld = 1'b0;
  logic        key_flag = 1'b0;
  logic [23:0] disp_data;
  logic [5:0]  dot_mask;
  logic [5:0]  blank_mask;
  logic        page;
  logic        data_err;

  rtc_disp_mux #(
    .HALF_SEC_MAX (25'd9),
    .RETURN_TICKS (5'd3)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rstn   (sys_rstn),
    .time_bcd   (time_bcd),
    .time_vld   (time_vld),
    .key_flag   (key_flag),
    .disp_data  (disp_data),
    .dot_mask   (dot_mask),
    .blank_mask (blank_mask),
    .page       (page),
    .data_err   (data_err)
  );

  always #5 sys_clk = ~sys_clk;

  // Edge index since reset release: the time base for all expectations.
  int edges = 0;
  always @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) edges <= 0;
    else           edges <= edges + 1;
  end

  typedef struct {
    string       tag;
    int          due;
    logic [23:0] disp;
    logic [5:0]  dot;
    logic [5:0]  blank;
    logic        pg;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   ent, rtn, base;

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // ill = the page shown at 'due' contains an illegal field.
  function automatic void push(input string tag, input int due, input logic [23:0] d,
                               input logic pg, input bit ill);
    exp_t e;
    bit   err;
    err     = ill && CHK;
    e.tag   = tag;
    e.due   = due;
    e.disp  = d;
    e.dot   = 6'b010100;
    e.pg    = pg;
    e.err   = err;
    e.blank = (err && ((due / PER) % 2 == 1)) ? 6'h3F : 6'h00;
    sb.push_back(e);
  endfunction

  function automatic void push_rst(input string tag);
    exp_t e;
    e.tag   = tag;
    e.due   = edges;
    e.disp  = '0;
    e.dot   = '0;
    e.pg    = 1'b0;
    e.err   = 1'b0;
    e.blank = '0;
    sb.push_back(e);
  endfunction

  task automatic check_due();
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= edges) begin
      e = sb.pop_front();
      chk({e.tag, " edge"},  24'(edges),      24'(e.due));
      chk({e.tag, " disp"},  disp_data,       e.disp);
      chk({e.tag, " page"},  24'(page),       24'(e.pg));
      chk({e.tag, " dot"},   24'(dot_mask),   24'(e.dot));
      chk({e.tag, " err"},   24'(data_err),   24'(e.err));
      chk({e.tag, " blank"}, 24'(blank_mask), 24'(e.blank));
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
    check_due();
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 200 && edges < target; i++) cyc();
  endtask

  task automatic pulse_vld(input logic [47:0] d);
    time_bcd = d;
    time_vld = 1'b1;
    cyc();
    time_vld = 1'b0;
  endtask

  task automatic pulse_key();
    key_flag = 1'b1;
    cyc();
    key_flag = 1'b0;
  endtask

  initial begin
    #22 sys_rstn = 1'b1;
    push_rst("reset");
    check_due();
    push("idle", edges + 1, 24'h000000, 1'b0, 1'b0);
    cyc();

    // Load and show the time page.
    push("t1 load", edges + 2, 24'h191800, 1'b0, 1'b0);
    pulse_vld(T1);
    cyc();

    // Toggle to DATE and back.
    push("to date pg",   edges + 1, 24'h191800, 1'b1, 1'b0);
    push("to date data", edges + 2, 24'h231214, 1'b1, 1'b0);
    pulse_key();
    cyc();
    push("to time pg",   edges + 1, 24'h231214, 1'b0, 1'b0);
    push("to time data", edges + 2, 24'h191800, 1'b0, 1'b0);
    pulse_key();
    cyc();

    // Strobe and key together, then auto-return after RT ticks in DATE.
    ent = edges + 1;
    rtn = (ent / PER + RT) * PER;
    push("vld+key pg",    ent,     24'h191800, 1'b1, 1'b0);
    push("vld+key data",  ent + 1, 24'h240131, 1'b1, 1'b0);
    push("pre return",    rtn - 1, 24'h240131, 1'b1, 1'b0);
    push("auto return",   rtn,     24'h240131, 1'b0, 1'b0);
    push("return data",   rtn + 1, 24'h235959, 1'b0, 1'b0);
    time_bcd = T2;
    time_vld = 1'b1;
    key_flag = 1'b1;
    cyc();
    time_vld = 1'b0;
    key_flag = 1'b0;
    run_to(rtn + 1);

    // Key coincident with the timeout tick: single transition to TIME.
    ent = edges + 1;
    rtn = (ent / PER + RT) * PER;
    push("date2 pg",       ent,     24'h235959, 1'b1, 1'b0);
    push("date2 data",     ent + 1, 24'h240131, 1'b1, 1'b0);
    push("coinc pre",      rtn - 1, 24'h240131, 1'b1, 1'b0);
    push("coinc edge",     rtn,     24'h240131, 1'b0, 1'b0);
    push("coinc data",     rtn + 1, 24'h235959, 1'b0, 1'b0);
    push("coinc settled",  rtn + 3, 24'h235959, 1'b0, 1'b0);
    pulse_key();
    run_to(rtn - 1);
    pulse_key();
    run_to(rtn + 3);

    // Illegal seconds on the time page, observed across several ticks.
    base = edges;
    push("ss5a prev", base + 1, 24'h235959, 1'b0, 1'b0);
    for (int k = 2; k <= 25; k++) push("ss5a", base + k, 24'h12345A, 1'b0, 1'b1);
    pulse_vld(T3);
    run_to(base + 25);

    // Legal date page clears the error; returning shows it again.
    ent = edges + 1;
    push("ill date pg",   ent,     24'h12345A, 1'b1, 1'b1);
    push("ill date data", ent + 1, 24'h231214, 1'b1, 1'b0);
    push("ill date hold", ent + 2, 24'h231214, 1'b1, 1'b0);
    pulse_key();
    cyc();
    cyc();
    push("ill back pg",   edges + 1, 24'h231214, 1'b0, 1'b0);
    push("ill back data", edges + 2, 24'h12345A, 1'b0, 1'b1);
    pulse_key();
    cyc();

    // Hour 24 on time page; month 13 / day 00 on date page.
    push("hh24", edges + 2, 24'h240000, 1'b0, 1'b1);
    pulse_vld(T4);
    cyc();
    ent = edges + 1;
    push("mo13 pg",   ent,     24'h240000, 1'b1, 1'b1);
    push("mo13 data", ent + 1, 24'h991300, 1'b1, 1'b1);
    pulse_key();
    cyc();
    repeat (12) cyc();

    // Asynchronous reset while in DATE with a partial timeout count.
    #3 sys_rstn = 1'b0;
    #1;
    push_rst("async rst");
    check_due();
    #10;
    push_rst("rst held");
    check_due();
    sys_rstn = 1'b1;
    push("post rst", edges + 1, 24'h000000, 1'b0, 1'b0);
    cyc();
    push("repopulate", edges + 2, 24'h191800, 1'b0, 1'b0);
    pulse_vld(T1);
    cyc();

    // Full timeout after reset: counter restarted from zero.
    ent = edges + 1;
    rtn = (ent / PER + RT) * PER;
    push("rst date pg",   ent,     24'h191800, 1'b1, 1'b0);
    push("rst date data", ent + 1, 24'h231214, 1'b1, 1'b0);
    push("rst pre ret",   rtn - 1, 24'h231214, 1'b1, 1'b0);
    push("rst return",    rtn,     24'h231214, 1'b0, 1'b0);
    pulse_key();
    run_to(rtn);

    chk("scoreboard drained", 24'(sb.size()), 24'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
